layer_pass_sched: RTL

//  Top-level pass sequencer for one conv layer. Walks the M-tile (outer) x C-tile (inner) pass grid.
//  Per pass: launches weight and ifmap GLB loaders in parallel, waits for both, launches PE-array compute.

---
 rtl/accel_pkg.sv | 22 ++
 rtl/pass_done_join.sv | 33 +++
 rtl/layer_pass_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Purpose: shared constants for the layer pass sequencer (state encoding, default widths).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accel_pkg;

    // Default widths for pass indices and the per-phase watchdog.
    localparam int MP_W_DEF   = 4;
    localparam int CP_W_DEF   = 6;
    localparam int WDOG_W_DEF = 16;

    // Sequencer state encoding. Each ISSUE state always precedes its WAIT state,
    // so the watchdog is guaranteed to be zero on WAIT entry.
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD_ISSUE = 3'd1;
    localparam logic [2:0] ST_LOAD_WAIT  = 3'd2;
    localparam logic [2:0] ST_COMP_ISSUE = 3'd3;
    localparam logic [2:0] ST_COMP_WAIT  = 3'd4;
    localparam logic [2:0] ST_WB_ISSUE   = 3'd5;
    localparam logic [2:0] ST_WB_WAIT    = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

endpackage

// File: rtl/pass_done_join.sv
// Purpose: joins two 1-cycle done pulses with sticky latches; o_both fires once both have been seen.
// Latency: combinational - o_both is high in the cycle the second pulse arrives (or both together).
// Backpressure: none; latches hold until i_clr, which takes priority over new set pulses.
module pass_done_join (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_set_a,
    input  logic i_set_b,
    input  logic i_clr,
    output logic o_both
);

    logic lat_a;
    logic lat_b;

    // Sticky capture of each done pulse until the owner clears the join.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lat_a <= 1'b0;
            lat_b <= 1'b0;
        end else if (i_clr) begin
            lat_a <= 1'b0;
            lat_b <= 1'b0;
        end else begin
            lat_a <= lat_a | i_set_a;
            lat_b <= lat_b | i_set_b;
        end
    end

    // Include the current-cycle pulses so a same-cycle pair completes immediately.
    assign o_both = (lat_a | i_set_a) & (lat_b | i_set_b);

endmodule

// File: rtl/layer_pass_sched.sv
// Purpose: walks the M-tile (outer) x C-tile (inner) pass grid: loads, compute, psum writeback per M tile.
// Latency: every start pulse appears exactly one cycle after its triggering event (start / done pulse).
// Backpressure: waits indefinitely on done pulses, bounded by a per-phase watchdog that aborts to IDLE with o_err.
module layer_pass_sched
    import accel_pkg::*;
#(
    parameter int MP_W   = MP_W_DEF,
    parameter int CP_W   = CP_W_DEF,
    parameter int WDOG_W = WDOG_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_layer_start,
    input  logic [MP_W-1:0] i_num_pass_m,
    input  logic [CP_W-1:0] i_num_pass_c,
    output logic            o_wght_load_start,
    input  logic            i_wght_load_done,
    output logic            o_ifmap_load_start,
    input  logic            i_ifmap_load_done,
    output logic            o_compute_start,
    input  logic            i_compute_done,
    output logic            o_psum_acc_en,
    output logic            o_psum_wb_start,
    input  logic            i_psum_wb_done,
    output logic [MP_W-1:0] o_pass_m_idx,
    output logic [CP_W-1:0] o_pass_c_idx,
    output logic            o_busy,
    output logic            o_layer_done,
    output logic            o_err
);

    // Counter value one below all-ones: the increment from here makes the watchdog
    // reach all-ones, which is the timeout point.
    localparam logic [WDOG_W-1:0] WDOG_LAST = ~WDOG_W'(1);

    logic [2:0]        state;
    logic [MP_W-1:0]   m_idx;
    logic [MP_W-1:0]   m_last;
    logic [CP_W-1:0]   c_idx;
    logic [CP_W-1:0]   c_last;
    logic              acc_en;
    logic              err;
    logic [WDOG_W-1:0] wdog;

    logic in_wait;
    logic wdog_expire;
    logic in_load_wait;
    logic loads_done;
    logic join_clr;

    assign in_wait      = (state == ST_LOAD_WAIT) || (state == ST_COMP_WAIT) || (state == ST_WB_WAIT);
    assign wdog_expire  = in_wait && (wdog == WDOG_LAST);
    assign in_load_wait = (state == ST_LOAD_WAIT);

    // Latches are dropped when compute is issued, and held clear while idle so an
    // aborted layer cannot leak a stale done into the next one.
    assign join_clr = (state == ST_COMP_ISSUE) || (state == ST_IDLE);

    pass_done_join u_load_join (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_set_a (in_load_wait & i_wght_load_done),
        .i_set_b (in_load_wait & i_ifmap_load_done),
        .i_clr   (join_clr),
        .o_both  (loads_done)
    );

    // Watchdog: zero outside WAIT states, count every cycle spent inside one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog <= '0;
        end else if (!in_wait) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end

    // Pass sequencer: state, pass indices, accumulate flag and sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            m_idx  <= '0;
            c_idx  <= '0;
            m_last <= '0;
            c_last <= '0;
            acc_en <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_layer_start) begin
                        // A zero pass count runs as a single pass.
                        m_last <= (i_num_pass_m == '0) ? '0 : i_num_pass_m - 1'b1;
                        c_last <= (i_num_pass_c == '0) ? '0 : i_num_pass_c - 1'b1;
                        m_idx  <= '0;
                        c_idx  <= '0;
                        acc_en <= 1'b0;
                        err    <= 1'b0;
                        state  <= ST_LOAD_ISSUE;
                    end
                end
                ST_LOAD_ISSUE: begin
                    state <= ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: begin
                    if (loads_done) begin
                        state <= ST_COMP_ISSUE;
                    end else if (wdog_expire) begin
                        err    <= 1'b1;
                        m_idx  <= '0;
                        c_idx  <= '0;
                        acc_en <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_COMP_ISSUE: begin
                    state <= ST_COMP_WAIT;
                end
                ST_COMP_WAIT: begin
                    if (i_compute_done) begin
                        if (c_idx == c_last) begin
                            state <= ST_WB_ISSUE;
                        end else begin
                            // Every C pass after the first accumulates onto the stored psum.
                            c_idx  <= c_idx + 1'b1;
                            acc_en <= 1'b1;
                            state  <= ST_LOAD_ISSUE;
                        end
                    end else if (wdog_expire) begin
                        err    <= 1'b1;
                        m_idx  <= '0;
                        c_idx  <= '0;
                        acc_en <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_WB_ISSUE: begin
                    state <= ST_WB_WAIT;
                end
                ST_WB_WAIT: begin
                    if (i_psum_wb_done) begin
                        if (m_idx == m_last) begin
                            state <= ST_DONE;
                        end else begin
                            m_idx  <= m_idx + 1'b1;
                            c_idx  <= '0;
                            acc_en <= 1'b0;
                            state  <= ST_LOAD_ISSUE;
                        end
                    end else if (wdog_expire) begin
                        err    <= 1'b1;
                        m_idx  <= '0;
                        c_idx  <= '0;
                        acc_en <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    m_idx  <= '0;
                    c_idx  <= '0;
                    acc_en <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Start pulses and status are decoded straight from the registered state.
    assign o_wght_load_start  = (state == ST_LOAD_ISSUE);
    assign o_ifmap_load_start = (state == ST_LOAD_ISSUE);
    assign o_compute_start    = (state == ST_COMP_ISSUE);
    assign o_psum_wb_start    = (state == ST_WB_ISSUE);
    assign o_layer_done       = (state == ST_DONE);
    assign o_busy             = (state != ST_IDLE);
    assign o_psum_acc_en      = acc_en;
    assign o_pass_m_idx       = m_idx;
    assign o_pass_c_idx       = c_idx;
    assign o_err              = err;

endmodule
